// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph codes, glyph-to-segment table and converter states
package seg_pkg;

  localparam logic [4:0] G_0     = 5'd0;
  localparam logic [4:0] G_1     = 5'd1;
  localparam logic [4:0] G_2     = 5'd2;
  localparam logic [4:0] G_3     = 5'd3;
  localparam logic [4:0] G_4     = 5'd4;
  localparam logic [4:0] G_5     = 5'd5;
  localparam logic [4:0] G_6     = 5'd6;
  localparam logic [4:0] G_7     = 5'd7;
  localparam logic [4:0] G_8     = 5'd8;
  localparam logic [4:0] G_9     = 5'd9;
  localparam logic [4:0] G_A     = 5'd10;
  localparam logic [4:0] G_B     = 5'd11;
  localparam logic [4:0] G_C     = 5'd12;
  localparam logic [4:0] G_D     = 5'd13;
  localparam logic [4:0] G_E     = 5'd14;
  localparam logic [4:0] G_G     = 5'd15;
  localparam logic [4:0] G_H     = 5'd16;
  localparam logic [4:0] G_I     = 5'd17;
  localparam logic [4:0] G_J     = 5'd18;
  localparam logic [4:0] G_L     = 5'd19;
  localparam logic [4:0] G_N     = 5'd20;
  localparam logic [4:0] G_O     = 5'd21;
  localparam logic [4:0] G_P     = 5'd22;
  localparam logic [4:0] G_R     = 5'd23;
  localparam logic [4:0] G_S     = 5'd24;
  localparam logic [4:0] G_T     = 5'd25;
  localparam logic [4:0] G_U     = 5'd26;
  localparam logic [4:0] G_Y     = 5'd27;
  localparam logic [4:0] G_MINUS = 5'd28;
  localparam logic [4:0] G_BLANK = 5'd31;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  // Active-high segment pattern, bit order dp g f e d c b a; unknown codes are dark
  function automatic logic [7:0] glyph_seg(input logic [4:0] code);
    logic [7:0] seg;
    case (code)
      G_0:     seg = 8'h3F;
      G_1:     seg = 8'h06;
      G_2:     seg = 8'h5B;
      G_3:     seg = 8'h4F;
      G_4:     seg = 8'h66;
      G_5:     seg = 8'h6D;
      G_6:     seg = 8'h7D;
      G_7:     seg = 8'h07;
      G_8:     seg = 8'h7F;
      G_9:     seg = 8'h6F;
      G_A:     seg = 8'h77;
      G_B:     seg = 8'h7C;
      G_C:     seg = 8'h39;
      G_D:     seg = 8'h5E;
      G_E:     seg = 8'h79;
      G_G:     seg = 8'h3D;
      G_H:     seg = 8'h76;
      G_I:     seg = 8'h06;
      G_J:     seg = 8'h1E;
      G_L:     seg = 8'h38;
      G_N:     seg = 8'h54;
      G_O:     seg = 8'h5C;
      G_P:     seg = 8'h73;
      G_R:     seg = 8'h50;
      G_S:     seg = 8'h6D;
      G_T:     seg = 8'h78;
      G_U:     seg = 8'h3E;
      G_Y:     seg = 8'h6E;
      G_MINUS: seg = 8'h40;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter with valid/ready request
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W     = 32,
  parameter int NUM_FIELD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   num_valid,
  output logic                   num_ready,
  input  logic [BIN_W-1:0]       num_bin,
  output logic [4*NUM_FIELD-1:0] bcd_out,
  output logic                   num_ovf
);

  localparam int BCD_W = 4 * NUM_FIELD;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t      state, state_nxt;
  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] work;
  logic [BCD_W-1:0] work_adj;
  logic             sticky;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;

  assign last_bit = (bit_cnt == CNT_W'(BIN_W - 1));

  // Add-3 correction on every nibble that would reach 10 or more after the shift
  always_comb begin
    work_adj = work;
    for (int k = 0; k < NUM_FIELD; k++) begin
      if (work[4*k +: 4] >= 4'd5) begin
        work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
      end
    end
  end

  // Next-state and ready decode
  always_comb begin
    state_nxt = state;
    num_ready = 1'b0;
    case (state)
      CONV_IDLE: begin
        num_ready = 1'b1;
        if (num_valid) state_nxt = CONV_SHIFT;
      end
      CONV_SHIFT: begin
        if (last_bit) state_nxt = CONV_DONE;
      end
      CONV_DONE: begin
        state_nxt = CONV_IDLE;
      end
      default: begin
        state_nxt = CONV_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CONV_IDLE;
    else        state <= state_nxt;
  end

  // Working shift registers; the display copy only changes in DONE so it never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sh  <= '0;
      work    <= '0;
      sticky  <= 1'b0;
      bit_cnt <= '0;
      bcd_out <= '0;
      num_ovf <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (num_valid) begin
            bin_sh  <= num_bin;
            work    <= '0;
            sticky  <= 1'b0;
            bit_cnt <= '0;
          end
        end
        CONV_SHIFT: begin
          work    <= {work_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
          bin_sh  <= bin_sh << 1;
          sticky  <= sticky | work_adj[BCD_W-1];
          bit_cnt <= bit_cnt + 1'b1;
        end
        CONV_DONE: begin
          bcd_out <= work;
          num_ovf <= sticky;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/seg_mux_bcd_driver.sv
// rtl/seg_mux_bcd_driver.sv - multiplexed seven-segment driver with decimal field overlay
module seg_mux_bcd_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int NUM_FIELD       = 4,
  parameter int BIN_W           = 32,
  parameter int SCAN_DIV_W      = 17,
  parameter int BLINK_DIV_W     = 25,
  parameter int SEG_ACTIVE_HIGH = 1,
  parameter int AN_ACTIVE_LOW   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [4:0]                    wr_code,
  input  logic                          num_valid,
  output logic                          num_ready,
  input  logic [BIN_W-1:0]              num_bin,
  input  logic                          num_show,
  input  logic                          lz_blank,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic                          num_ovf,
  output logic [7:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         seg_an
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [4:0]             glyph_buf [NUM_DIGITS];
  logic [SCAN_DIV_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]       scan_idx;
  logic [BLINK_DIV_W-1:0] blink_cnt;
  logic                   blink_phase;
  logic [4*NUM_FIELD-1:0] bcd_disp;
  logic [NUM_FIELD-1:0]   lead_zero;
  logic                   in_field;
  logic [3:0]             field_nib;
  logic                   field_lz;
  logic [4:0]             code_sel;
  logic [7:0]             seg_lit;
  logic [NUM_DIGITS-1:0]  an_onehot;

  bin2bcd_seq #(
    .BIN_W     (BIN_W),
    .NUM_FIELD (NUM_FIELD)
  ) u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .num_valid (num_valid),
    .num_ready (num_ready),
    .num_bin   (num_bin),
    .bcd_out   (bcd_disp),
    .num_ovf   (num_ovf)
  );

  // Glyph buffer; addresses past the last digit are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) glyph_buf[i] <= G_BLANK;
    end else if (wr_en && (32'(wr_addr) < NUM_DIGITS)) begin
      glyph_buf[wr_addr] <= wr_code;
    end
  end

  // Scan prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt) begin
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end
    end
  end

  // Blink phase divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (&blink_cnt) blink_phase <= ~blink_phase;
    end
  end

  // lead_zero[k]: nibble k and every nibble above it are zero
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_FIELD-1] = (bcd_disp[4*NUM_FIELD-1 -: 4] == 4'd0);
    for (int k = NUM_FIELD - 2; k >= 0; k--) begin
      lead_zero[k] = lead_zero[k+1] & (bcd_disp[4*k +: 4] == 4'd0);
    end
  end

  // Pick the number-field nibble for the digit being scanned
  always_comb begin
    in_field  = 1'b0;
    field_nib = 4'd0;
    field_lz  = 1'b0;
    for (int k = 0; k < NUM_FIELD; k++) begin
      if (32'(scan_idx) == k) begin
        in_field  = 1'b1;
        field_nib = bcd_disp[4*k +: 4];
        field_lz  = (k != 0) && lead_zero[k];
      end
    end
  end

  // Glyph selection, field overlay and blink for the current digit
  always_comb begin
    code_sel = glyph_buf[scan_idx];
    if (num_show && in_field) begin
      if (num_ovf)                   code_sel = G_MINUS;
      else if (lz_blank && field_lz) code_sel = G_BLANK;
      else                           code_sel = {1'b0, field_nib};
    end
    seg_lit = glyph_seg(code_sel);
    if (blink_phase && blink_mask[scan_idx]) seg_lit = 8'h00;
    an_onehot = NUM_DIGITS'(1) << scan_idx;
  end

  // Pins registered together so anode and segments switch on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_an  <= (AN_ACTIVE_LOW != 0) ? '1 : '0;
      seg_out <= (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;
    end else begin
      seg_an  <= (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
      seg_out <= (SEG_ACTIVE_HIGH != 0) ? seg_lit : ~seg_lit;
    end
  end

endmodule
